// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch buffer.
package ifetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, inst} pairs with a registered head.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_kept;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Effective push/pop and the occupancy after this cycle.
  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    rd_next    = rd_ptr + PW'(do_pop);
    count_kept = count - CW'(do_pop);
    count_next = count_kept + CW'(do_push);
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  // Pointers, count and the registered head. The new head is the incoming
  // word only when nothing older survives this cycle; otherwise it comes
  // from storage at the advanced read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      count <= count_next;
      if (count_next != '0)
        head <= (count_kept == '0) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: owns the PC, issues one word fetch at a time, buffers the
// returned words and hands them to the decoder; redirect flushes everything.
module ifetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  import ifetch_pkg::*;

  state_t              state;
  state_t              state_next;
  logic [31:0]         pc;
  logic [31:0]         pc_next;
  logic [31:0]         pend_pc;
  logic [31:0]         pend_next;
  logic                push;
  logic [2*INST_W-1:0] push_data;
  logic [2*INST_W-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;

  assign req_addr   = pc;
  assign push_data  = {pend_pc, resp_data};
  assign inst_valid = ~fifo_empty;
  assign inst_pc    = head[2*INST_W-1:INST_W];
  assign inst       = head[INST_W-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (inst_valid & inst_ready),
    .flush (redirect_valid),
    .din   (push_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State, PC and the address of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_next;
    end
  end

  // Request issue, response acceptance and redirect handling. req_valid is
  // also held low while rst is high so it reads as 0 during reset.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend_pc;
    req_valid  = 1'b0;
    push       = 1'b0;
    case (state)
      S_IDLE: begin
        req_valid = ~fifo_full & ~redirect_valid & ~rst;
        if (req_valid && req_ready) begin
          pc_next    = pc + PC_INC;
          pend_next  = pc;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid)
          state_next = resp_valid ? S_IDLE : S_DROP;
        else if (resp_valid) begin
          push       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (resp_valid)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (redirect_valid)
      pc_next = redirect_pc & ~32'h3;
  end

  // A response with nothing outstanding is a memory protocol error.
  assert property (@(posedge clk) disable iff (rst) !(state == S_IDLE && resp_valid));

endmodule
